// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - instruction fetch stage with redirect kill and stall buffer
module instruction_fetch_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        stall,
    input  logic [31:0] imem_readdata,
    input  logic        imem_busywait,
    output logic        imem_read,
    output logic [31:0] imem_address,
    output logic [31:0] OUT_pc,
    output logic [31:0] OUT_pc_plus_4,
    output logic [31:0] OUT_instruction,
    output logic        fetch_busywait
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, REQ, HELD} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic        kill, kill_nxt;
    logic [31:0] redirect_pc, redirect_pc_nxt;
    logic [31:0] buf_pc, buf_pc_nxt;
    logic [31:0] buf_instr, buf_instr_nxt;

    logic [31:0] target_aligned;
    logic        response;

    assign target_aligned = branch_target & ~32'd3;
    assign response       = (state == REQ) && !imem_busywait;

    // State register; reset takes effect immediately so an in-flight read is dropped
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            pc          <= 32'd0;
            kill        <= 1'b0;
            redirect_pc <= 32'd0;
            buf_pc      <= 32'd0;
            buf_instr   <= NOP;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            kill        <= kill_nxt;
            redirect_pc <= redirect_pc_nxt;
            buf_pc      <= buf_pc_nxt;
            buf_instr   <= buf_instr_nxt;
        end
    end

    // Next-state: redirects beat stalls, stalls beat sequential advance
    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        kill_nxt        = kill;
        redirect_pc_nxt = redirect_pc;
        buf_pc_nxt      = buf_pc;
        buf_instr_nxt   = buf_instr;
        case (state)
            IDLE: begin
                if (branch_taken) pc_nxt = target_aligned;
                state_nxt = REQ;
            end
            REQ: begin
                if (!response) begin
                    // memory still busy: remember the redirect, keep the address stable
                    if (branch_taken) begin
                        kill_nxt        = 1'b1;
                        redirect_pc_nxt = target_aligned;
                    end
                end else if (branch_taken) begin
                    pc_nxt   = target_aligned;
                    kill_nxt = 1'b0;
                end else if (kill) begin
                    pc_nxt   = redirect_pc;
                    kill_nxt = 1'b0;
                end else if (stall) begin
                    buf_pc_nxt    = pc;
                    buf_instr_nxt = imem_readdata;
                    state_nxt     = HELD;
                end else begin
                    pc_nxt = pc + 32'd4;
                end
            end
            HELD: begin
                if (branch_taken) begin
                    pc_nxt    = target_aligned;
                    state_nxt = REQ;
                end else if (!stall) begin
                    pc_nxt    = buf_pc + 32'd4;
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: a real instruction only on a clean response or from the held buffer
    always_comb begin
        imem_read       = 1'b0;
        imem_address    = pc;
        OUT_pc          = pc;
        OUT_instruction = NOP;
        fetch_busywait  = 1'b1;
        case (state)
            REQ: begin
                imem_read = 1'b1;
                if (response && !kill && !branch_taken && !stall) begin
                    OUT_instruction = imem_readdata;
                    fetch_busywait  = 1'b0;
                end
            end
            HELD: begin
                OUT_pc          = buf_pc;
                OUT_instruction = buf_instr;
                fetch_busywait  = stall || branch_taken;
            end
            default: ;
        endcase
        OUT_pc_plus_4 = OUT_pc + 32'd4;
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed vectors plus randomized model check for instruction_fetch_unit
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        stall = 1'b0;
    logic [31:0] imem_readdata;
    logic        imem_busywait = 1'b0;
    logic        imem_read;
    logic [31:0] imem_address;
    logic [31:0] OUT_pc;
    logic [31:0] OUT_pc_plus_4;
    logic [31:0] OUT_instruction;
    logic        fetch_busywait;

    instruction_fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .stall           (stall),
        .imem_readdata   (imem_readdata),
        .imem_busywait   (imem_busywait),
        .imem_read       (imem_read),
        .imem_address    (imem_address),
        .OUT_pc          (OUT_pc),
        .OUT_pc_plus_4   (OUT_pc_plus_4),
        .OUT_instruction (OUT_instruction),
        .fetch_busywait  (fetch_busywait)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0050_0093;
            32'h0000_0004: return 32'h0010_8113;
            32'h0000_0010: return 32'hDEAD_BEEF;
            default:       return a + 32'h1000_0000;
        endcase
    endfunction

    always_comb imem_readdata = mem_word(imem_address);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic e_read, input logic [31:0] e_addr,
                             input logic e_fb, input logic [31:0] e_pc, input logic [31:0] e_instr,
                             input logic chk_out);
        logic [31:0] e_pc4;
        e_pc4 = e_pc + 32'd4;
        check({tag, " imem_read"}, {31'd0, imem_read}, {31'd0, e_read});
        if (e_read || !reset) check({tag, " imem_address"}, imem_address, e_addr);
        check({tag, " fetch_busywait"}, {31'd0, fetch_busywait}, {31'd0, e_fb});
        if (chk_out) begin
            check({tag, " OUT_pc"}, OUT_pc, e_pc);
            check({tag, " OUT_pc_plus_4"}, OUT_pc_plus_4, e_pc4);
            check({tag, " OUT_instruction"}, OUT_instruction, e_instr);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        stl;
        logic        busy;
        logic        br;
        logic [31:0] tgt;
        logic        e_read;
        logic [31:0] e_addr;
        logic        e_fb;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        chk_out;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic stl, input logic busy, input logic br,
                                input logic [31:0] tgt, input logic e_read, input logic [31:0] e_addr,
                                input logic e_fb, input logic [31:0] e_pc, input logic [31:0] e_instr,
                                input logic chk_out);
        vec_t v;
        v.rst = rst; v.stl = stl; v.busy = busy; v.br = br; v.tgt = tgt;
        v.e_read = e_read; v.e_addr = e_addr; v.e_fb = e_fb; v.e_pc = e_pc;
        v.e_instr = e_instr; v.chk_out = chk_out;
        return v;
    endfunction

    // Behavioural reference: phase 0 = waiting after reset, 1 = fetching, 2 = holding
    int          m_phase;
    logic [31:0] m_pc, m_hold_pc, m_hold_instr;
    logic [31:0] m_redirect_q[$];
    logic        x_read, x_fb, x_chk;
    logic [31:0] x_pc, x_instr;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    task automatic model_reset();
        m_phase = 0; m_pc = 32'd0; m_hold_pc = 32'd0; m_hold_instr = NOP;
        m_redirect_q.delete();
    endtask

    task automatic model_eval();
        x_read = (m_phase == 1); x_fb = 1'b1; x_pc = m_pc; x_instr = NOP; x_chk = 1'b1;
        if (m_phase == 1) begin
            if (!imem_busywait && m_redirect_q.size() == 0 && !branch_taken && !stall) begin
                x_fb = 1'b0;
                x_instr = mem_word(m_pc);
            end
        end else if (m_phase == 2) begin
            x_pc = m_hold_pc; x_instr = m_hold_instr;
            x_fb = stall || branch_taken;
            x_chk = !branch_taken;
        end
    endtask

    task automatic model_step();
        if (m_phase == 0) begin
            if (branch_taken) m_pc = word_align(branch_target);
            m_phase = 1;
        end else if (m_phase == 1) begin
            if (imem_busywait) begin
                if (branch_taken) begin
                    m_redirect_q.delete();
                    m_redirect_q.push_back(word_align(branch_target));
                end
            end else if (branch_taken) begin
                m_pc = word_align(branch_target);
                m_redirect_q.delete();
            end else if (m_redirect_q.size() != 0) begin
                m_pc = m_redirect_q.pop_front();
            end else if (stall) begin
                m_hold_pc = m_pc; m_hold_instr = mem_word(m_pc); m_phase = 2;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end else begin
            if (branch_taken) begin
                m_pc = word_align(branch_target); m_phase = 1;
            end else if (!stall) begin
                m_pc = m_hold_pc + 32'd4; m_phase = 1;
            end
        end
    endtask

    initial begin
        // reset state while reset is held low
        @(negedge clk);
        #1;
        check_all("reset", 1'b0, 32'd0, 1'b1, 32'd0, NOP, 1'b1);

        vecs.push_back(mk(1,0,0,0,32'h0,         0,32'h0,       1,32'h0,       NOP,          1));
        vecs.push_back(mk(1,0,0,0,32'h0,         1,32'h0,       0,32'h0,       32'h00500093, 1));
        vecs.push_back(mk(1,0,0,0,32'h0,         1,32'h4,       0,32'h4,       32'h00108113, 1));
        vecs.push_back(mk(1,0,1,0,32'h0,         1,32'h8,       1,32'h8,       NOP,          1));
        vecs.push_back(mk(1,0,1,0,32'h0,         1,32'h8,       1,32'h8,       NOP,          1));
        vecs.push_back(mk(1,0,1,0,32'h0,         1,32'h8,       1,32'h8,       NOP,          1));
        vecs.push_back(mk(1,0,0,0,32'h0,         1,32'h8,       0,32'h8,       32'h10000008, 1));
        vecs.push_back(mk(1,0,0,0,32'h0,         1,32'hC,       0,32'hC,       32'h1000000C, 1));
        vecs.push_back(mk(1,1,0,0,32'h0,         1,32'h10,      1,32'h10,      NOP,          1));
        vecs.push_back(mk(1,1,0,0,32'h0,         0,32'h10,      1,32'h10,      32'hDEADBEEF, 1));
        vecs.push_back(mk(1,0,0,0,32'h0,         0,32'h10,      0,32'h10,      32'hDEADBEEF, 1));
        vecs.push_back(mk(1,0,0,0,32'h0,         1,32'h14,      0,32'h14,      32'h10000014, 1));
        vecs.push_back(mk(1,0,0,0,32'h0,         1,32'h18,      0,32'h18,      32'h10000018, 1));
        vecs.push_back(mk(1,0,0,0,32'h0,         1,32'h1C,      0,32'h1C,      32'h1000001C, 1));
        vecs.push_back(mk(1,0,1,1,32'h103,       1,32'h20,      1,32'h20,      NOP,          1));
        vecs.push_back(mk(1,0,1,0,32'h0,         1,32'h20,      1,32'h20,      NOP,          1));
        vecs.push_back(mk(1,0,0,0,32'h0,         1,32'h20,      1,32'h20,      NOP,          1));
        vecs.push_back(mk(1,0,0,0,32'h0,         1,32'h100,     0,32'h100,     32'h10000100, 1));
        vecs.push_back(mk(1,1,0,0,32'h0,         1,32'h104,     1,32'h104,     NOP,          1));
        vecs.push_back(mk(1,0,0,1,32'h40,        0,32'h104,     1,32'h104,     32'h10000104, 0));
        vecs.push_back(mk(1,0,0,0,32'h0,         1,32'h40,      0,32'h40,      32'h10000040, 1));
        vecs.push_back(mk(1,0,0,1,32'hFFFFFFFC,  1,32'h44,      1,32'h44,      NOP,          1));
        vecs.push_back(mk(1,0,0,0,32'h0,         1,32'hFFFFFFFC,0,32'hFFFFFFFC,32'h0FFFFFFC, 1));
        vecs.push_back(mk(1,0,0,0,32'h0,         1,32'h0,       0,32'h0,       32'h00500093, 1));
        vecs.push_back(mk(1,0,1,0,32'h0,         1,32'h4,       1,32'h4,       NOP,          1));
        vecs.push_back(mk(0,0,1,0,32'h0,         0,32'h0,       1,32'h0,       NOP,          1));
        vecs.push_back(mk(1,0,0,0,32'h0,         0,32'h0,       1,32'h0,       NOP,          1));
        vecs.push_back(mk(1,0,0,0,32'h0,         1,32'h0,       0,32'h0,       32'h00500093, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset         = vecs[i].rst;
            stall         = vecs[i].stl;
            imem_busywait = vecs[i].busy;
            branch_taken  = vecs[i].br;
            branch_target = vecs[i].tgt;
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].e_read, vecs[i].e_addr, vecs[i].e_fb,
                      vecs[i].e_pc, vecs[i].e_instr, vecs[i].chk_out);
        end

        // reset asserted in the middle of a busy cycle, away from any clock edge
        @(negedge clk);
        imem_busywait = 1'b1;
        #1;
        check_all("midwait_before", 1'b1, 32'h4, 1'b1, 32'h4, NOP, 1'b1);
        #1 reset = 1'b0;
        #1;
        check_all("midwait_after", 1'b0, 32'h0, 1'b1, 32'h0, NOP, 1'b1);

        // randomized run against the reference model, with occasional reset pulses
        model_reset();
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            reset         = ($urandom_range(99) != 0);
            stall         = ($urandom_range(3) == 0);
            imem_busywait = ($urandom_range(9) < 3);
            branch_taken  = ($urandom_range(19) == 0);
            branch_target = $urandom;
            #1;
            if (!reset) begin
                model_reset();
                check_all($sformatf("rnd%0d", c), 1'b0, 32'd0, 1'b1, 32'd0, NOP, 1'b1);
            end else begin
                model_eval();
                check_all($sformatf("rnd%0d", c), x_read, m_pc, x_fb, x_pc, x_instr, x_chk);
                model_step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 clk  in  1  rising-edge clock; all state changes on posedge clk.
REQ-002 reset  in  1  asynchronous, active-low reset; reset=0 forces reset state immediately, independent of clk.
REQ-003 branch_taken  in  1  redirect request from EX; valid while asserted.
REQ-004 branch_target  in  32  redirect address; bits [1:0] ignored and treated as 0.
REQ-005 stall  in  1  hold request from hazard unit; the IF/ID register must not advance.
REQ-006 imem_readdata  in  32  instruction word from instruction memory; valid in the cycle imem_read=1 and imem_busywait=0.
REQ-007 imem_busywait  in  1  instruction memory not ready.
REQ-008 imem_read  out  1  instruction memory read request.
REQ-009 imem_address  out  32  instruction memory word address (byte address, [1:0]=0).
REQ-010 OUT_pc  out  32  PC of the presented instruction, to IF/ID IN_pc.
REQ-011 OUT_pc_plus_4  out  32  OUT_pc+4, to IF/ID IN_pc_plus_4.
REQ-012 OUT_instruction  out  32  presented instruction, to IF/ID IN_instruction.
REQ-013 fetch_busywait  out  1  1 = outputs not valid this cycle; drives IF/ID busywait and PC hold.

Function
REQ-014 State: pc (32), FSM {IDLE, REQ, HELD}, kill flag, redirect_pc (32), buffer {buf_pc, buf_instr}.
REQ-015 IDLE: imem_read=0, fetch_busywait=1; next posedge -> REQ.
REQ-016 REQ: imem_read=1, imem_address=pc; address held stable until imem_busywait=0 is sampled.
REQ-017 REQ, imem_busywait=1: fetch_busywait=1; remain REQ.
REQ-018 REQ response (imem_busywait=0), kill=0, branch_taken=0, stall=0: OUT_pc=pc, OUT_instruction=imem_readdata, fetch_busywait=0; posedge: pc<=pc+4, stay REQ (back-to-back fetch, one instruction per response).
REQ-019 REQ response, stall=1, branch_taken=0, kill=0: fetch_busywait=1; posedge: buf_pc<=pc, buf_instr<=imem_readdata, pc unchanged, -> HELD.
REQ-020 REQ, branch_taken=1 with imem_busywait=1: posedge: kill<=1, redirect_pc<=branch_target; request continues to old address.
REQ-021 REQ response with kill=1: data discarded, fetch_busywait=1; posedge: pc<=redirect_pc, kill<=0, stay REQ; a new branch_taken in the same cycle overrides (pc<=branch_target).
REQ-022 REQ response with branch_taken=1: data discarded, fetch_busywait=1; posedge: pc<=branch_target, kill<=0.
REQ-023 HELD: imem_read=0; OUT_pc=buf_pc, OUT_instruction=buf_instr, fetch_busywait=stall; posedge with stall=0: pc<=buf_pc+4, -> REQ.
REQ-024 HELD, branch_taken=1: buffer dropped, fetch_busywait=1; posedge: pc<=branch_target, -> REQ.
REQ-025 Priority per cycle: reset > branch_taken/kill > stall > normal advance.
REQ-026 OUT_pc_plus_4 = OUT_pc+4 modulo 2^32; pc 0xFFFFFFFC advances to 0x00000000.
REQ-027 When fetch_busywait=1 and not HELD, OUT_instruction=0x00000013 (NOP), OUT_pc=pc.
REQ-028 Latency: reset release to first valid instruction = 2 cycles + memory wait cycles; steady state 1 instruction per response.

Reset
REQ-029 reset=0: pc=0, FSM=IDLE, kill=0, redirect_pc=0, buf_pc=0, buf_instr=0x00000013, imem_read=0, imem_address=0, fetch_busywait=1, OUT_pc=0, OUT_pc_plus_4=4, OUT_instruction=0x00000013.
REQ-030 Reset asserted mid-request drops imem_read within the same cycle; any in-flight response is ignored.

Verification
REQ-031 Release reset, memory 0-wait returning 0x00500093 @0, 0x00108113 @4 -> fetch_busywait low from 3rd posedge; OUT_pc 0,4 with matching instructions on consecutive cycles.
REQ-032 imem_busywait high 3 cycles at pc=0x8 -> imem_address=0x8 stable, fetch_busywait=1 for 3 cycles, then OUT_pc=0x8, OUT_pc_plus_4=0xC.
REQ-033 stall=1 on response at pc=0x10 (instr 0xDEADBEEF), held 2 cycles -> imem_read=0, OUT_instruction=0xDEADBEEF throughout, fetch_busywait=1 then 0; next fetch at 0x14.
REQ-034 branch_taken pulse (target 0x103) during miss at pc=0x20 -> response for 0x20 discarded, next imem_address=0x100, no instruction from 0x20 presented.
REQ-035 branch_taken in HELD (target 0x40) -> buffer dropped, next imem_address=0x40.
REQ-036 pc=0xFFFFFFFC response -> OUT_pc_plus_4=0x0, next imem_address=0x0; reset pulse mid-wait -> imem_read=0 immediately, restart at 0x0.
